scaler_axis_cfggen: RTL and testbench
=====================================

SCALER_AXIS_CFGGEN -- requirements
Module: scaler_axis_cfggen

Interface
REQ-001 Parameter IN_W, default 10, width of input line/pixel counts.
REQ-002 Parameter OUT_W, default 12, width of output/active counts.
REQ-003 Parameter FRAC_W, default 17, fractional bits of the interpolation factor; quotient width QW = FRAC_W+1.
REQ-004 SYS_CLK  in  1  sole clock; all logic rising-edge.
REQ-005 SYS_RST  in  1  reset, synchronous, active-high.
REQ-006 n_in_full_i  in  IN_W  source lines/pixels per frame on this axis.
REQ-007 n_box_ref_i  in  IN_W  reference count used in boxed mode.
REQ-008 box_i  in  1  boxed mode enable.
REQ-009 n_active_i  in  OUT_W  active output window size.
REQ-010 n_out_i  in  OUT_W  scaled image size (divisor).
REQ-011 recalc_i  in  1  single-cycle forced recompute request.
REQ-012 busy_o  out  1  computation in progress.
REQ-013 cfg_valid_o  out  1  one-cycle pulse, new config registered.
REQ-014 err_o  out  1  last request had n_out_i = 0.
REQ-015 interp_factor_o  out  QW  floor(2^FRAC_W / n_out).
REQ-016 first_rd_o  out  IN_W  first input line/pixel to read.
REQ-017 in_needed_o  out  IN_W  input lines/pixels needed.
REQ-018 in_full_o  out  IN_W  latched n_in_full.
REQ-019 out_o  out  OUT_W  latched n_out.
REQ-020 allow_slemu_o  out  1  scanline emulation allowed.

Function
REQ-021 FSM states IDLE, DIV, MUL1, MUL2, CALC, OUT; only IDLE accepts requests.
REQ-022 Shadow registers hold n_in_full, n_box_ref, box, n_active, n_out of last accepted request.
REQ-023 IDLE: request when any input differs from shadow, or pending flag set; on accept, shadows load, pending clears, busy_o=1, next state DIV (or OUT-with-error if n_out_i=0).
REQ-024 recalc_i in any state sets pending; input changes during busy are detected on return to IDLE via shadow compare.
REQ-025 DIV: restoring serial division of 2^FRAC_W by n_out, exactly QW cycles, one quotient bit per cycle, MSB first.
REQ-026 MUL1: inv = quotient * n_in_full (QW+IN_W bits).
REQ-027 MUL2: prod = inv * n_active (QW+IN_W+OUT_W bits).
REQ-028 CALC: resmax = prod[..FRAC_W] + prod[FRAC_W-1] (round half up), saturated to IN_W+1 bits.
REQ-029 Normal mode: ref = n_in_full; needed = min(resmax, ref); first = (n_in_full - needed) >> 1 (0 if resmax >= n_in_full).
REQ-030 Boxed mode: ref = n_box_ref; needed = min(resmax, ref); first = (n_in_full - needed) >> 1.
REQ-031 allow_slemu = (n_out >= 2*n_in_full), compared at OUT_W+1 bits.
REQ-032 OUT: all outputs load in one cycle, cfg_valid_o=1, err_o=0, busy_o=0, next IDLE; accept-to-cfg_valid_o latency exactly QW+4 cycles.
REQ-033 Error path (n_out=0): one cycle in OUT with err_o=1, cfg_valid_o=0, data outputs hold previous values; busy_o deasserts.
REQ-034 Outputs change only in OUT; stable otherwise.
REQ-035 Earliest next accept is the cycle after OUT.

Reset
REQ-036 SYS_RST high: state IDLE, all outputs 0, shadows 0, pending=1; reset mid-computation aborts it with no cfg_valid_o.
REQ-037 First cycle after reset release accepts a request (pending=1).

Verification
REQ-038 Defaults, in_full=240, out=960, active=960, box=0 -> after 22 cycles: factor 136, needed 239, first 0, slemu 1, valid pulse.
REQ-039 in_full=240, out=1440, active=960 -> factor 91, needed 160, first 40, slemu 1.
REQ-040 box=1, in_full=288, ref=240, out=1200, active=1080 -> factor 109, resmax 259, needed 240, first 24, slemu 1.
REQ-041 out=0 -> err_o=1, no cfg_valid_o, outputs unchanged; then out=480, in_full=240 -> err_o=0, factor 273, slemu 1.
REQ-042 Change n_out during DIV plus recalc_i pulse -> exactly one extra computation after OUT, ending with values for the new n_out.
REQ-043 SYS_RST during MUL1 -> all outputs 0, no pulse; recompute starts the cycle after release.

Source files
------------

// File: rtl/scaler_axis_cfggen.sv
// Per-axis scaler configuration generator: serial reciprocal of the output size, then
// input window (needed lines/pixels, first line) and scanline-emulation eligibility.
module scaler_axis_cfggen #(
    parameter int unsigned IN_W   = 10,
    parameter int unsigned OUT_W  = 12,
    parameter int unsigned FRAC_W = 17,
    localparam int unsigned QW    = FRAC_W + 1
) (
    input  logic              SYS_CLK,
    input  logic              SYS_RST,
    input  logic [IN_W-1:0]   n_in_full_i,
    input  logic [IN_W-1:0]   n_box_ref_i,
    input  logic              box_i,
    input  logic [OUT_W-1:0]  n_active_i,
    input  logic [OUT_W-1:0]  n_out_i,
    input  logic              recalc_i,
    output logic              busy_o,
    output logic              cfg_valid_o,
    output logic              err_o,
    output logic [QW-1:0]     interp_factor_o,
    output logic [IN_W-1:0]   first_rd_o,
    output logic [IN_W-1:0]   in_needed_o,
    output logic [IN_W-1:0]   in_full_o,
    output logic [OUT_W-1:0]  out_o,
    output logic              allow_slemu_o
);

    localparam int unsigned PW  = QW + IN_W + OUT_W;
    localparam int unsigned PRW = PW - FRAC_W + 1;
    localparam int unsigned CW  = $clog2(QW);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StDiv  = 3'd1;
    localparam logic [2:0] StMul1 = 3'd2;
    localparam logic [2:0] StMul2 = 3'd3;
    localparam logic [2:0] StCalc = 3'd4;
    localparam logic [2:0] StOut  = 3'd5;

    logic [2:0]          state_q, state_d;
    logic                pending_q;
    logic [IN_W-1:0]     in_full_q, box_ref_q;
    logic                box_q;
    logic [OUT_W-1:0]    active_q, nout_q;

    logic [QW-1:0]       dvd_q, quot_q;
    logic [OUT_W-1:0]    rem_q;
    logic [CW-1:0]       cnt_q;
    logic [QW+IN_W-1:0]  inv_q;
    // Product pre-shifted so bit 0 is the rounding bit (weight 2^(FRAC_W-1)).
    logic [PRW-1:0]      prod_q;

    logic                busy_q, cfg_valid_q, err_q, slemu_q;
    logic [QW-1:0]       factor_q;
    logic [IN_W-1:0]     first_q, needed_q, full_out_q;
    logic [OUT_W-1:0]    out_q;

    logic                req;
    logic [OUT_W:0]      rem_sh;
    logic                rem_ge;
    logic [PRW-1:0]      resmax_full;
    logic [IN_W:0]       resmax;
    logic [IN_W-1:0]     ref_c, needed_c, first_c;
    logic [OUT_W:0]      twice_in;
    logic                slemu_c;

    always_comb begin
        req = pending_q
            || (n_in_full_i != in_full_q) || (n_box_ref_i != box_ref_q)
            || (box_i != box_q) || (n_active_i != active_q) || (n_out_i != nout_q);

        rem_sh = {rem_q, dvd_q[QW-1]};
        rem_ge = rem_sh >= {1'b0, nout_q};

        resmax_full = {1'b0, prod_q[PRW-1:1]} + PRW'(prod_q[0]);
        if (|resmax_full[PRW-1:IN_W+1]) begin
            resmax = '1;
        end else begin
            resmax = resmax_full[IN_W:0];
        end

        ref_c = box_q ? box_ref_q : in_full_q;
        if (resmax < {1'b0, ref_c}) begin
            needed_c = resmax[IN_W-1:0];
        end else begin
            needed_c = ref_c;
        end

        if (needed_c >= in_full_q) begin
            first_c = '0;
        end else begin
            first_c = (in_full_q - needed_c) >> 1;
        end

        twice_in = {{(OUT_W-IN_W){1'b0}}, in_full_q, 1'b0};
        slemu_c  = {1'b0, nout_q} >= twice_in;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (req) state_d = (n_out_i == '0) ? StOut : StDiv;
            StDiv:  if (cnt_q == CW'(QW - 1)) state_d = StMul1;
            StMul1: state_d = StMul2;
            StMul2: state_d = StCalc;
            StCalc: state_d = StOut;
            StOut:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            state_q     <= StIdle;
            pending_q   <= 1'b1;
            in_full_q   <= '0;
            box_ref_q   <= '0;
            box_q       <= 1'b0;
            active_q    <= '0;
            nout_q      <= '0;
            dvd_q       <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            inv_q       <= '0;
            prod_q      <= '0;
            busy_q      <= 1'b0;
            cfg_valid_q <= 1'b0;
            err_q       <= 1'b0;
            slemu_q     <= 1'b0;
            factor_q    <= '0;
            first_q     <= '0;
            needed_q    <= '0;
            full_out_q  <= '0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            cfg_valid_q <= 1'b0;
            busy_q      <= (state_d == StDiv) || (state_d == StMul1)
                        || (state_d == StMul2) || (state_d == StCalc);

            if (recalc_i) begin
                pending_q <= 1'b1;
            end else if (state_q == StIdle && req) begin
                pending_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (req) begin
                        in_full_q <= n_in_full_i;
                        box_ref_q <= n_box_ref_i;
                        box_q     <= box_i;
                        active_q  <= n_active_i;
                        nout_q    <= n_out_i;
                        dvd_q     <= QW'(1) << FRAC_W;
                        quot_q    <= '0;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        if (n_out_i == '0) err_q <= 1'b1;
                    end
                end
                StDiv: begin
                    dvd_q  <= dvd_q << 1;
                    quot_q <= {quot_q[QW-2:0], rem_ge};
                    rem_q  <= rem_ge ? OUT_W'(rem_sh - {1'b0, nout_q}) : rem_sh[OUT_W-1:0];
                    cnt_q  <= cnt_q + 1'b1;
                end
                StMul1: inv_q <= (QW+IN_W)'(quot_q) * (QW+IN_W)'(in_full_q);
                StMul2: prod_q <= PRW'((PW'(inv_q) * PW'(active_q)) >> (FRAC_W - 1));
                StCalc: begin
                    // Registered here so the new config is visible during the OUT cycle.
                    factor_q    <= quot_q;
                    needed_q    <= needed_c;
                    first_q     <= first_c;
                    slemu_q     <= slemu_c;
                    full_out_q  <= in_full_q;
                    out_q       <= nout_q;
                    cfg_valid_q <= 1'b1;
                    err_q       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign cfg_valid_o     = cfg_valid_q;
    assign err_o           = err_q;
    assign interp_factor_o = factor_q;
    assign first_rd_o      = first_q;
    assign in_needed_o     = needed_q;
    assign in_full_o       = full_out_q;
    assign out_o           = out_q;
    assign allow_slemu_o   = slemu_q;

endmodule

// File: tb/tb_scaler_axis_cfggen.sv
// Directed bench for scaler_axis_cfggen with hand-computed expected configurations.
module tb_scaler_axis_cfggen;

    localparam int IN_W = 10, OUT_W = 12, FRAC_W = 17, QW = FRAC_W + 1;

    logic              SYS_CLK = 1'b0;
    logic              SYS_RST = 1'b1;
    logic [IN_W-1:0]   n_in_full_i, n_box_ref_i;
    logic              box_i, recalc_i;
    logic [OUT_W-1:0]  n_active_i, n_out_i;
    logic              busy_o, cfg_valid_o, err_o, allow_slemu_o;
    logic [QW-1:0]     interp_factor_o;
    logic [IN_W-1:0]   first_rd_o, in_needed_o, in_full_o;
    logic [OUT_W-1:0]  out_o;

    int n_tests = 0;
    int n_fail  = 0;

    scaler_axis_cfggen dut (
        .SYS_CLK         (SYS_CLK),
        .SYS_RST         (SYS_RST),
        .n_in_full_i     (n_in_full_i),
        .n_box_ref_i     (n_box_ref_i),
        .box_i           (box_i),
        .n_active_i      (n_active_i),
        .n_out_i         (n_out_i),
        .recalc_i        (recalc_i),
        .busy_o          (busy_o),
        .cfg_valid_o     (cfg_valid_o),
        .err_o           (err_o),
        .interp_factor_o (interp_factor_o),
        .first_rd_o      (first_rd_o),
        .in_needed_o     (in_needed_o),
        .in_full_o       (in_full_o),
        .out_o           (out_o),
        .allow_slemu_o   (allow_slemu_o)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge SYS_CLK);
        @(negedge SYS_CLK);
    endtask

    // Counts cycles until cfg_valid_o; 0 reported on timeout.
    task automatic wait_valid(input string tag, input int exp_lat);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 60) begin
            step();
            n++;
            if (cfg_valid_o) seen = 1'b1;
        end
        check({tag, "_latency"}, seen ? n : 0, exp_lat);
    endtask

    task automatic check_cfg(input string tag, input int fac, input int need, input int first,
                             input int slemu, input int full, input int out);
        check({tag, "_factor"}, 32'(interp_factor_o), fac);
        check({tag, "_needed"}, 32'(in_needed_o), need);
        check({tag, "_first"},  32'(first_rd_o), first);
        check({tag, "_slemu"},  32'(allow_slemu_o), slemu);
        check({tag, "_full"},   32'(in_full_o), full);
        check({tag, "_out"},    32'(out_o), out);
        check({tag, "_busy"},   32'(busy_o), 0);
        check({tag, "_err"},    32'(err_o), 0);
    endtask

    initial begin
        int pulses;
        int first_fac;

        n_in_full_i = 10'd240;
        n_box_ref_i = 10'd0;
        box_i       = 1'b0;
        n_active_i  = 12'd960;
        n_out_i     = 12'd960;
        recalc_i    = 1'b0;
        repeat (3) step();

        check("rst_valid",  32'(cfg_valid_o), 0);
        check("rst_busy",   32'(busy_o), 0);
        check("rst_factor", 32'(interp_factor_o), 0);
        check("rst_needed", 32'(in_needed_o), 0);
        check("rst_out",    32'(out_o), 0);

        // Basic 4x upscale, accepted on the first cycle after reset release
        SYS_RST = 1'b0;
        step();
        check("t1_busy_running", 32'(busy_o), 1);
        wait_valid("t1", QW + 3);
        check_cfg("t1", 136, 239, 0, 1, 240, 960);
        step();
        check("t1_valid_one_cycle", 32'(cfg_valid_o), 0);

        // Active window smaller than scaled image
        n_out_i = 12'd1440;
        wait_valid("t2", QW + 4);
        check_cfg("t2", 91, 160, 40, 1, 240, 1440);
        step();

        // Boxed mode, resmax clipped to reference count
        box_i       = 1'b1;
        n_in_full_i = 10'd288;
        n_box_ref_i = 10'd240;
        n_out_i     = 12'd1200;
        n_active_i  = 12'd1080;
        wait_valid("t3", QW + 4);
        check_cfg("t3", 109, 240, 24, 1, 288, 1200);
        step();

        // Divide by zero: error, no pulse, outputs held
        n_out_i = 12'd0;
        step();
        check("t4_err",    32'(err_o), 1);
        check("t4_valid",  32'(cfg_valid_o), 0);
        check("t4_busy",   32'(busy_o), 0);
        check("t4_factor", 32'(interp_factor_o), 109);
        check("t4_needed", 32'(in_needed_o), 240);
        check("t4_out",    32'(out_o), 1200);
        pulses = 0;
        repeat (5) begin
            step();
            if (cfg_valid_o) pulses++;
        end
        check("t4_no_pulse", pulses, 0);

        box_i       = 1'b0;
        n_in_full_i = 10'd240;
        n_active_i  = 12'd960;
        n_out_i     = 12'd480;
        wait_valid("t5", QW + 4);
        check_cfg("t5", 273, 240, 0, 1, 240, 480);
        step();

        // n_out change plus recalc during DIV: one extra computation only
        n_out_i = 12'd960;
        repeat (5) step();
        n_out_i  = 12'd1440;
        recalc_i = 1'b1;
        step();
        recalc_i  = 1'b0;
        pulses    = 0;
        first_fac = 0;
        repeat (80) begin
            step();
            if (cfg_valid_o) begin
                pulses++;
                if (pulses == 1) first_fac = 32'(interp_factor_o);
            end
        end
        check("t6_pulses",     pulses, 2);
        check("t6_first_fac",  first_fac, 136);
        check_cfg("t6", 91, 160, 40, 1, 240, 1440);

        // Divisor of one: full-width factor, slemu not allowed
        n_out_i    = 12'd1;
        n_active_i = 12'd1;
        wait_valid("t7", QW + 4);
        check_cfg("t7", 131072, 240, 0, 0, 240, 1);
        step();

        // Reset while in MUL1 aborts the computation
        n_out_i    = 12'd960;
        n_active_i = 12'd960;
        repeat (QW + 1) step();
        check("t8_busy_mul1", 32'(busy_o), 1);
        SYS_RST = 1'b1;
        step();
        check("t8_rst_valid",  32'(cfg_valid_o), 0);
        check("t8_rst_busy",   32'(busy_o), 0);
        check("t8_rst_factor", 32'(interp_factor_o), 0);
        check("t8_rst_slemu",  32'(allow_slemu_o), 0);
        check("t8_rst_full",   32'(in_full_o), 0);
        step();
        check("t8_rst_valid2", 32'(cfg_valid_o), 0);
        SYS_RST = 1'b0;
        wait_valid("t8", QW + 4);
        check_cfg("t8", 136, 239, 0, 1, 240, 960);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
